// File: rtl/seg_scan_pkg.sv
// Shared constants for the 7-segment scan decoder: anode codes, segment patterns,
// frame FSM states and the digit-code-to-binary helper.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        WAIT3,
        GOT3,
        GOT2,
        GOT1
    } state_t;

    // Anode selects are active-low one-hot; pos3 is the leftmost digit.
    localparam logic [3:0] SEG_POS3 = 4'b0111;
    localparam logic [3:0] SEG_POS2 = 4'b1011;
    localparam logic [3:0] SEG_POS1 = 4'b1101;
    localparam logic [3:0] SEG_POS0 = 4'b1110;
    localparam logic [3:0] SEG_IDLE = 4'b1111;

    // Segment patterns a..g, active-low, bit 6 = a.
    localparam logic [6:0] PAT_0     = 7'b0000001;
    localparam logic [6:0] PAT_1     = 7'b1001111;
    localparam logic [6:0] PAT_2     = 7'b0010010;
    localparam logic [6:0] PAT_3     = 7'b0000110;
    localparam logic [6:0] PAT_4     = 7'b1001100;
    localparam logic [6:0] PAT_5     = 7'b0100100;
    localparam logic [6:0] PAT_6     = 7'b0100000;
    localparam logic [6:0] PAT_7     = 7'b0001111;
    localparam logic [6:0] PAT_8     = 7'b0000000;
    localparam logic [6:0] PAT_9     = 7'b0000100;
    localparam logic [6:0] PAT_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

    // Blank and invalid codes contribute nothing to the binary value.
    function automatic logic [13:0] code_value(input logic [3:0] c);
        return (c <= 4'd9) ? {10'd0, c} : 14'd0;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Display-side bundle: sampled scan lines in, published frame and pulses out.
interface seg_scan_decoder_if;
    logic [3:0]  seg;
    logic [6:0]  a_to_g;
    logic [15:0] digits;
    logic [13:0] value;
    logic        valid;
    logic        err;

    modport master (
        output seg,
        output a_to_g,
        input  digits,
        input  value,
        input  valid,
        input  err
    );

    modport slave (
        input  seg,
        input  a_to_g,
        output digits,
        output value,
        output valid,
        output err
    );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to digit code: 0-9, F for blank, E for anything else.
module seg7_pattern_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] a_to_g,
    output logic [3:0] code
);

    always_comb begin
        code = CODE_ERR;
        case (a_to_g)
            PAT_0:     code = 4'd0;
            PAT_1:     code = 4'd1;
            PAT_2:     code = 4'd2;
            PAT_3:     code = 4'd3;
            PAT_4:     code = 4'd4;
            PAT_5:     code = 4'd5;
            PAT_6:     code = 4'd6;
            PAT_7:     code = 4'd7;
            PAT_8:     code = 4'd8;
            PAT_9:     code = 4'd9;
            PAT_BLANK: code = CODE_BLANK;
            default:   code = CODE_ERR;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers left-to-right frames from a multiplexed 4-digit 7-segment scan and
// publishes a frame once it has repeated STABLE_FRAMES times in a row.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES = 2
) (
    input logic               CLK,
    input logic               RST,
    seg_scan_decoder_if.slave bus
);

    localparam logic [3:0]  STABLE_CNT = 4'(STABLE_FRAMES);
    localparam logic [13:0] WEIGHT [4] = '{14'd1, 14'd10, 14'd100, 14'd1000};

    logic [3:0]  seg_reg;
    logic [6:0]  pattern_reg;
    logic [3:0]  code;
    state_t      state_reg, state_next;
    logic [3:0]  cap_reg  [4];
    logic [3:0]  cap_next [4];
    logic [15:0] prev_reg, prev_next;
    logic [15:0] digits_reg, digits_next;
    logic [13:0] value_reg, value_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [3:0]  cnt_inc;
    logic        valid_reg, valid_next;
    logic        err_reg;
    logic        scan_err, frame_err, complete, stable_hit;
    logic        is_pos3, is_pos2, is_pos1, is_pos0, is_idle, is_legal;
    logic [15:0] frame;
    logic [3:0]  nib_is_err;
    logic [13:0] nib_weighted [4];
    logic [13:0] frame_value;

    seg7_pattern_decode u_decode (
        .a_to_g (pattern_reg),
        .code   (code)
    );

    assign is_pos3  = (seg_reg == SEG_POS3);
    assign is_pos2  = (seg_reg == SEG_POS2);
    assign is_pos1  = (seg_reg == SEG_POS1);
    assign is_pos0  = (seg_reg == SEG_POS0);
    assign is_idle  = (seg_reg == SEG_IDLE);
    assign is_legal = is_pos3 | is_pos2 | is_pos1 | is_pos0;

    // The completing pos0 digit is taken straight from the decoder, not from cap_reg.
    assign frame = {cap_reg[3], cap_reg[2], cap_reg[1], code};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nibble
            assign nib_is_err[gi]   = (frame[gi*4 +: 4] == CODE_ERR);
            assign nib_weighted[gi] = code_value(frame[gi*4 +: 4]) * WEIGHT[gi];
        end
    endgenerate

    assign frame_value = nib_weighted[0] + nib_weighted[1] + nib_weighted[2] + nib_weighted[3];

    always_comb begin
        state_next = state_reg;
        cap_next   = cap_reg;
        scan_err   = 1'b0;
        complete   = 1'b0;
        if (!is_idle) begin
            if (!is_legal) begin
                scan_err   = 1'b1;
                state_next = WAIT3;
            end else begin
                case (state_reg)
                    WAIT3: begin
                        if (is_pos3) begin
                            cap_next[3] = code;
                            state_next  = GOT3;
                        end else begin
                            scan_err = 1'b1;
                        end
                    end
                    GOT3: begin
                        if (is_pos3) begin
                            cap_next[3] = code;
                        end else if (is_pos2) begin
                            cap_next[2] = code;
                            state_next  = GOT2;
                        end else begin
                            scan_err   = 1'b1;
                            state_next = WAIT3;
                        end
                    end
                    GOT2: begin
                        if (is_pos2) begin
                            cap_next[2] = code;
                        end else if (is_pos1) begin
                            cap_next[1] = code;
                            state_next  = GOT1;
                        end else if (is_pos3) begin
                            scan_err    = 1'b1;
                            cap_next[3] = code;
                            state_next  = GOT3;
                        end else begin
                            scan_err   = 1'b1;
                            state_next = WAIT3;
                        end
                    end
                    GOT1: begin
                        if (is_pos1) begin
                            cap_next[1] = code;
                        end else if (is_pos0) begin
                            complete   = 1'b1;
                            state_next = WAIT3;
                        end else if (is_pos3) begin
                            scan_err    = 1'b1;
                            cap_next[3] = code;
                            state_next  = GOT3;
                        end else begin
                            scan_err   = 1'b1;
                            state_next = WAIT3;
                        end
                    end
                    default: state_next = WAIT3;
                endcase
            end
        end
    end

    // Stability tracking and publish decision for a completed frame.
    always_comb begin
        prev_next   = prev_reg;
        cnt_next    = cnt_reg;
        digits_next = digits_reg;
        value_next  = value_reg;
        valid_next  = 1'b0;
        frame_err   = 1'b0;
        stable_hit  = 1'b0;
        cnt_inc     = (cnt_reg == 4'hF) ? 4'hF : cnt_reg + 4'd1;
        if (complete) begin
            if (|nib_is_err) begin
                frame_err = 1'b1;
                cnt_next  = 4'd0;
            end else if (frame == prev_reg) begin
                cnt_next   = cnt_inc;
                stable_hit = (cnt_inc == STABLE_CNT) && (cnt_reg != STABLE_CNT);
            end else begin
                cnt_next   = 4'd1;
                prev_next  = frame;
                stable_hit = (STABLE_CNT == 4'd1);
            end
            if (stable_hit && (frame != digits_reg)) begin
                digits_next = frame;
                value_next  = frame_value;
                valid_next  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            seg_reg     <= SEG_IDLE;
            pattern_reg <= PAT_BLANK;
            state_reg   <= WAIT3;
            for (int i = 0; i < 4; i++) begin
                cap_reg[i] <= CODE_BLANK;
            end
            prev_reg    <= 16'hFFFF;
            digits_reg  <= 16'hFFFF;
            value_reg   <= 14'd0;
            cnt_reg     <= 4'd0;
            valid_reg   <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            seg_reg     <= bus.seg;
            pattern_reg <= bus.a_to_g;
            state_reg   <= state_next;
            cap_reg     <= cap_next;
            prev_reg    <= prev_next;
            digits_reg  <= digits_next;
            value_reg   <= value_next;
            cnt_reg     <= cnt_next;
            valid_reg   <= valid_next;
            err_reg     <= scan_err | frame_err;
        end
    end

    assign bus.digits = digits_reg;
    assign bus.value  = value_reg;
    assign bus.valid  = valid_reg;
    assign bus.err    = err_reg;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scenario bench for seg_scan_decoder with a frame-level reference model of the
// scan protocol, stability rule and publish outputs.
module tb_seg_scan_decoder;

    localparam int STABLE = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    seg_scan_decoder_if bus_if ();

    seg_scan_decoder #(.STABLE_FRAMES(STABLE)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model: m_cur is the position being captured (-1 = none), m_next the one expected.
    int          m_cur, m_next, m_cnt, m_val;
    int          m_cap [4];
    logic [15:0] m_prev, m_pub;
    bit          exp_valid, exp_err;
    logic [3:0]  h_seg;
    logic [6:0]  h_pat;

    int step_no = 0;
    int trace_bad, n_valid, n_err, last_valid_step, last_err_step;

    function automatic logic [6:0] dpat(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int pat2code(input logic [6:0] p);
        if (p == 7'h7F) return 15;
        for (int d = 0; d < 10; d++) begin
            if (dpat(d) == p) return d;
        end
        return 14;
    endfunction

    function automatic logic [3:0] pos_seg(input int i);
        logic [3:0] one;
        one = 4'b0001 << i;
        return ~one;
    endfunction

    function automatic logic [27:0] fpat(input int d3, input int d2, input int d1, input int d0);
        return {dpat(d3), dpat(d2), dpat(d1), dpat(d0)};
    endfunction

    task automatic model_reset();
        m_cur = -1; m_next = 3; m_cnt = 0; m_val = 0;
        for (int i = 0; i < 4; i++) m_cap[i] = 15;
        m_prev = 16'hFFFF; m_pub = 16'hFFFF;
        exp_valid = 0; exp_err = 0;
        h_seg = 4'hF; h_pat = 7'h7F;
    endtask

    task automatic model_frame();
        logic [15:0] fr;
        int          v;
        bit          bad, hit;
        int          old_cnt;
        fr = 0; v = 0; bad = 0; hit = 0;
        for (int i = 0; i < 4; i++) begin
            fr[i*4 +: 4] = 4'(m_cap[i]);
            if (m_cap[i] == 14) bad = 1;
            else if (m_cap[i] <= 9) v += m_cap[i] * (10 ** i);
        end
        if (bad) begin
            exp_err = 1;
            m_cnt = 0;
        end else if (fr == m_prev) begin
            old_cnt = m_cnt;
            m_cnt = (m_cnt >= 15) ? 15 : m_cnt + 1;
            hit = (m_cnt == STABLE) && (old_cnt != m_cnt);
        end else begin
            m_cnt = 1;
            m_prev = fr;
            hit = (STABLE == 1);
        end
        if (hit && fr != m_pub) begin
            m_pub = fr;
            m_val = v;
            exp_valid = 1;
        end
    endtask

    task automatic model_apply(input logic [3:0] s, input logic [6:0] p);
        int pos, code;
        exp_valid = 0; exp_err = 0;
        if (s == 4'hF) return;
        pos = -1;
        for (int i = 0; i < 4; i++) if (s == pos_seg(i)) pos = i;
        if (pos < 0) begin
            exp_err = 1; m_cur = -1; m_next = 3;
            return;
        end
        code = pat2code(p);
        if (pos == m_cur) begin
            m_cap[pos] = code;
            return;
        end
        if (pos == m_next) begin
            m_cap[pos] = code;
            if (pos == 0) begin
                m_cur = -1; m_next = 3;
                model_frame();
            end else begin
                m_cur = pos; m_next = pos - 1;
            end
            return;
        end
        exp_err = 1; m_cur = -1; m_next = 3;
        if (pos == 3) begin
            m_cap[3] = code; m_cur = 3; m_next = 2;
        end
    endtask

    // One clock of stimulus; the model retires the sample driven one cycle earlier,
    // which is what the DUT outputs reflect after this edge.
    task automatic step(input logic [3:0] s, input logic [6:0] p);
        @(negedge CLK);
        model_apply(h_seg, h_pat);
        h_seg = s; h_pat = p;
        bus_if.seg = s; bus_if.a_to_g = p;
        @(posedge CLK);
        #1;
        step_no++;
        if (bus_if.valid === 1'b1) begin
            n_valid++; last_valid_step = step_no;
            $display("publish step=%0d digits=%h value=%0d", step_no, bus_if.digits, bus_if.value);
        end
        if (bus_if.err === 1'b1) begin
            n_err++; last_err_step = step_no;
        end
        if (bus_if.valid !== exp_valid || bus_if.err !== exp_err ||
            bus_if.digits !== m_pub || bus_if.value !== 14'(m_val))
            trace_bad++;
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) step(4'hF, 7'h7F);
    endtask

    task automatic scan(input logic [27:0] pk, input int max_gap, input bit dup);
        for (int i = 3; i >= 0; i--) begin
            if (dup && $urandom_range(0, 3) == 0) step(pos_seg(i), dpat($urandom_range(0, 9)));
            step(pos_seg(i), pk[i*7 +: 7]);
            for (int g = $urandom_range(0, max_gap); g > 0; g--) step(4'hF, 7'($urandom));
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; bus_if.seg = 4'hF; bus_if.a_to_g = 7'h7F;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic clear_counts();
        trace_bad = 0; n_valid = 0; n_err = 0; last_valid_step = -1; last_err_step = -1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus_if.digits !== 16'hFFFF) begin errors++; $display("FAIL reset_digits: got %h want ffff", bus_if.digits); end
        checks++; if (bus_if.value !== 14'd0) begin errors++; $display("FAIL reset_value: got %0d want 0", bus_if.value); end
        checks++; if (bus_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus_if.valid); end
        checks++; if (bus_if.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus_if.err); end
    endtask

    task automatic test_stable_frame();
        int p0;
        clear_counts();
        scan(fpat(1, 2, 3, 4), 0, 0);
        scan(fpat(1, 2, 3, 4), 0, 0);
        p0 = step_no;
        scan(fpat(1, 2, 3, 4), 0, 0);
        scan(fpat(1, 2, 3, 4), 0, 0);
        flush(2);
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL stable_valid_count: got %0d want 1", n_valid); end
        checks++; if (last_valid_step !== p0 + 1) begin errors++; $display("FAIL stable_latency: got step %0d want %0d", last_valid_step, p0 + 1); end
        checks++; if (bus_if.digits !== 16'h1234) begin errors++; $display("FAIL stable_digits: got %h want 1234", bus_if.digits); end
        checks++; if (bus_if.value !== 14'd1234) begin errors++; $display("FAIL stable_value: got %0d want 1234", bus_if.value); end
        checks++; if (trace_bad !== 0) begin errors++; $display("FAIL stable_trace: got %0d bad cycles want 0", trace_bad); end
    endtask

    task automatic test_value_change();
        clear_counts();
        for (int f = 0; f < 3; f++) scan(fpat(0, 0, 0, 7), 0, 0);
        flush(2);
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL change_valid_count: got %0d want 1", n_valid); end
        checks++; if (bus_if.digits !== 16'h0007) begin errors++; $display("FAIL change_digits: got %h want 0007", bus_if.digits); end
        checks++; if (bus_if.value !== 14'd7) begin errors++; $display("FAIL change_value: got %0d want 7", bus_if.value); end
        do_reset();
        clear_counts();
        for (int f = 0; f < 3; f++) scan(fpat(0, 0, 0, 7), 3, 0);
        flush(2);
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL gap_valid_count: got %0d want 1", n_valid); end
        checks++; if (bus_if.digits !== 16'h0007) begin errors++; $display("FAIL gap_digits: got %h want 0007", bus_if.digits); end
        checks++; if (bus_if.value !== 14'd7) begin errors++; $display("FAIL gap_value: got %0d want 7", bus_if.value); end
        checks++; if (trace_bad !== 0) begin errors++; $display("FAIL change_trace: got %0d bad cycles want 0", trace_bad); end
    endtask

    task automatic test_out_of_order();
        int bad_step;
        clear_counts();
        step(pos_seg(3), dpat(5));
        step(pos_seg(1), dpat(6));
        bad_step = step_no;
        flush(2);
        checks++; if (n_err !== 1) begin errors++; $display("FAIL ooo_err_count: got %0d want 1", n_err); end
        checks++; if (last_err_step !== bad_step + 1) begin errors++; $display("FAIL ooo_err_latency: got step %0d want %0d", last_err_step, bad_step + 1); end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL ooo_no_publish: got %0d want 0", n_valid); end
        scan(fpat(5, 6, 7, 8), 0, 0);
        scan(fpat(5, 6, 7, 8), 0, 0);
        flush(2);
        checks++; if (bus_if.value !== 14'd5678) begin errors++; $display("FAIL ooo_value: got %0d want 5678", bus_if.value); end
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL ooo_valid_count: got %0d want 1", n_valid); end
        checks++; if (trace_bad !== 0) begin errors++; $display("FAIL ooo_trace: got %0d bad cycles want 0", trace_bad); end
    endtask

    task automatic test_invalid_pattern();
        int p0;
        clear_counts();
        scan({dpat(4), 7'b1111110, dpat(2), dpat(1)}, 0, 0);
        p0 = step_no;
        flush(2);
        checks++; if (n_err !== 1) begin errors++; $display("FAIL inv_err_count: got %0d want 1", n_err); end
        checks++; if (last_err_step !== p0 + 1) begin errors++; $display("FAIL inv_err_latency: got step %0d want %0d", last_err_step, p0 + 1); end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL inv_no_publish: got %0d want 0", n_valid); end
        scan(fpat(4, 3, 2, 1), 0, 0);
        scan(fpat(4, 3, 2, 1), 0, 0);
        flush(2);
        checks++; if (bus_if.value !== 14'd4321) begin errors++; $display("FAIL inv_value: got %0d want 4321", bus_if.value); end
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL inv_valid_count: got %0d want 1", n_valid); end
        checks++; if (trace_bad !== 0) begin errors++; $display("FAIL inv_trace: got %0d bad cycles want 0", trace_bad); end
    endtask

    task automatic test_all_blank();
        do_reset();
        clear_counts();
        for (int f = 0; f < 3; f++) scan(fpat(15, 15, 15, 15), 0, 0);
        flush(2);
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL blank_no_publish: got %0d want 0", n_valid); end
        checks++; if (bus_if.digits !== 16'hFFFF) begin errors++; $display("FAIL blank_digits: got %h want ffff", bus_if.digits); end
        scan(fpat(9, 9, 9, 9), 0, 0);
        scan(fpat(9, 9, 9, 9), 0, 0);
        flush(2);
        checks++; if (bus_if.digits !== 16'h9999) begin errors++; $display("FAIL nines_digits: got %h want 9999", bus_if.digits); end
        checks++; if (bus_if.value !== 14'd9999) begin errors++; $display("FAIL nines_value: got %0d want 9999", bus_if.value); end
        checks++; if (trace_bad !== 0) begin errors++; $display("FAIL blank_trace: got %0d bad cycles want 0", trace_bad); end
    endtask

    task automatic test_reset_mid_frame();
        clear_counts();
        step(pos_seg(3), dpat(3));
        step(pos_seg(2), dpat(1));
        do_reset();
        checks++; if (bus_if.digits !== 16'hFFFF) begin errors++; $display("FAIL mid_reset_digits: got %h want ffff", bus_if.digits); end
        checks++; if (bus_if.value !== 14'd0) begin errors++; $display("FAIL mid_reset_value: got %0d want 0", bus_if.value); end
        scan(fpat(3, 1, 4, 1), 0, 0);
        flush(2);
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL mid_early_publish: got %0d want 0", n_valid); end
        scan(fpat(3, 1, 4, 1), 0, 0);
        flush(2);
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL mid_valid_count: got %0d want 1", n_valid); end
        checks++; if (bus_if.value !== 14'd3141) begin errors++; $display("FAIL mid_value: got %0d want 3141", bus_if.value); end
        checks++; if (trace_bad !== 0) begin errors++; $display("FAIL mid_trace: got %0d bad cycles want 0", trace_bad); end
    endtask

    task automatic test_random();
        logic [27:0] fr;
        int reps;
        clear_counts();
        for (int it = 0; it < 200; it++) begin
            case ($urandom_range(0, 9))
                0: step(4'($urandom), 7'($urandom));
                1: scan({dpat($urandom_range(0, 9)), 7'($urandom), dpat(15), dpat($urandom_range(0, 9))}, 1, 1);
                default: begin
                    fr = fpat($urandom_range(0, 2), $urandom_range(0, 9), ($urandom_range(0, 4) == 0) ? 15 : 5, $urandom_range(0, 1));
                    reps = $urandom_range(1, 4);
                    for (int r = 0; r < reps; r++) scan(fr, 2, 1);
                end
            endcase
        end
        flush(2);
        checks++; if (trace_bad !== 0) begin errors++; $display("FAIL random_trace: got %0d bad cycles want 0", trace_bad); end
        checks++; if (n_valid == 0) begin errors++; $display("FAIL random_activity: got %0d publishes want >0", n_valid); end
    endtask

    initial begin
        bus_if.seg = 4'hF;
        bus_if.a_to_g = 7'h7F;
        model_reset();
        test_reset();
        test_stable_frame();
        test_value_change();
        test_out_of_order();
        test_invalid_pattern();
        test_all_blank();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
